sim_pcie_rx_tlp_gen: RTL

Simulation-only host-side TLP generator. It converts simple testbench commands into 32-bit AXI-stream TLPs and drives the core's RX port (m_axis_rx_*). It sits directly upstream of the core's receive engine and stands in for the root complex.

---
 rtl/sim_pcie_tlp_pkg.sv | 40 ++++
 rtl/sim_pcie_tlp_hdr_build.sv | 55 +++++
 rtl/sim_pcie_rx_tlp_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sim_pcie_tlp_pkg.sv
// Shared TLP encodings, command and FSM types for the simulated host-side TLP generator
// and the TX checker that will be built on the same header builder.
package sim_pcie_tlp_pkg;

    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    typedef enum logic [1:0] {
        CMD_MWR  = 2'd0,
        CMD_MRD  = 2'd1,
        CMD_CPLD = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NP_WAIT,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_DATA,
        ST_GAP
    } tlp_state_e;

    typedef struct packed {
        cmd_type_e   ctype;
        logic [31:0] addr;
        logic [9:0]  len;
        logic [7:0]  tag;
        logic [31:0] seed;
    } tlp_cmd_t;

    // A length field of zero encodes the maximum of 1024 DW.
    function automatic logic [10:0] dw_count(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/sim_pcie_tlp_hdr_build.sv
// Combinational builder of the three 3DW header DWs for MWr32, MRd32 and CplD.
module sim_pcie_tlp_hdr_build
    import sim_pcie_tlp_pkg::*;
#(
    parameter logic [15:0] REQ_ID = 16'h0000,
    parameter logic [15:0] CPL_ID = 16'h5552
) (
    input  cmd_type_e   cmd_type,
    input  logic [31:0] cmd_addr,
    input  logic [9:0]  cmd_len,
    input  logic [7:0]  cmd_tag,
    output logic [31:0] dw0,
    output logic [31:0] dw1,
    output logic [31:0] dw2
);

    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [11:0] byte_count;

    // {len, 2'b00} is exactly 12 bits, so len=0 naturally yields 0 (4096 bytes).
    assign byte_count = {cmd_len, 2'b00};

    always_comb begin
        fmt = FMT_3DW_DATA;
        typ = TYPE_MEM;
        dw1 = '0;
        dw2 = '0;
        case (cmd_type)
            CMD_MRD: begin
                fmt = FMT_3DW_NODATA;
                typ = TYPE_MEM;
            end
            CMD_CPLD: begin
                fmt = FMT_3DW_DATA;
                typ = TYPE_CPL;
            end
            default: begin
                fmt = FMT_3DW_DATA;
                typ = TYPE_MEM;
            end
        endcase

        dw0 = {1'b0, fmt, typ, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, cmd_len};

        if (cmd_type == CMD_CPLD) begin
            dw1 = {CPL_ID, 3'b000, 1'b0, byte_count};
            dw2 = {REQ_ID, cmd_tag, 1'b0, cmd_addr[6:0]};
        end else begin
            dw1 = {REQ_ID, cmd_tag, (cmd_len == 10'd1) ? 4'h0 : 4'hF, 4'hF};
            dw2 = {cmd_addr[31:2], 2'b00};
        end
    end

endmodule

// File: rtl/sim_pcie_rx_tlp_gen.sv
// Simulation host model: turns single-cycle commands into 32-bit AXI-stream TLPs
// on the core's RX port, with incrementing payloads and a fixed inter-packet gap.
module sim_pcie_rx_tlp_gen
    import sim_pcie_tlp_pkg::*;
#(
    parameter logic [15:0] REQ_ID     = 16'h0000,
    parameter logic [15:0] CPL_ID     = 16'h5552,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [6:0]  BAR_HIT    = 7'h01
) (
    input  logic        sys_clk_p,
    input  logic        sys_reset,
    input  logic        i_cmd_stb,
    output logic        o_cmd_rdy,
    input  logic [1:0]  i_cmd_type,
    input  logic [31:0] i_cmd_addr,
    input  logic [9:0]  i_cmd_len,
    input  logic [7:0]  i_cmd_tag,
    input  logic [31:0] i_cmd_seed,
    input  logic        rx_np_ok,
    output logic [31:0] m_axis_rx_tdata,
    output logic [3:0]  m_axis_rx_tkeep,
    output logic        m_axis_rx_tlast,
    output logic        m_axis_rx_tvalid,
    input  logic        m_axis_rx_tready,
    output logic [6:0]  o_bar_hit,
    output logic        o_busy,
    output logic [15:0] o_pkt_count,
    output logic        o_err_cmd
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    tlp_state_e  state, state_nxt;
    tlp_cmd_t    cmd;
    logic [10:0] dcnt;
    logic [31:0] pay;
    logic [15:0] gcnt;
    logic [31:0] hdr0, hdr1, hdr2;
    logic [10:0] n_dw;
    logic        accept, beat, last_data, is_mrd;
    tlp_state_e  done_state;

    sim_pcie_tlp_hdr_build #(
        .REQ_ID (REQ_ID),
        .CPL_ID (CPL_ID)
    ) u_hdr (
        .cmd_type (cmd.ctype),
        .cmd_addr (cmd.addr),
        .cmd_len  (cmd.len),
        .cmd_tag  (cmd.tag),
        .dw0      (hdr0),
        .dw1      (hdr1),
        .dw2      (hdr2)
    );

    assign n_dw       = dw_count(cmd.len);
    assign is_mrd     = (cmd.ctype == CMD_MRD);
    assign last_data  = (dcnt == n_dw);
    assign accept     = i_cmd_stb && o_cmd_rdy;
    assign beat       = m_axis_rx_tvalid && m_axis_rx_tready;
    assign done_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    assign o_cmd_rdy       = (state == ST_IDLE);
    assign o_busy          = (state != ST_IDLE);
    assign o_bar_hit       = BAR_HIT;
    assign m_axis_rx_tkeep = 4'hF;

    // Outputs decode straight from registered state, so they hold during stalls
    // and drop in the same timestep as an asynchronous reset.
    always_comb begin
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tdata  = '0;
        case (state)
            ST_HDR0: begin
                m_axis_rx_tvalid = 1'b1;
                m_axis_rx_tdata  = hdr0;
            end
            ST_HDR1: begin
                m_axis_rx_tvalid = 1'b1;
                m_axis_rx_tdata  = hdr1;
            end
            ST_HDR2: begin
                m_axis_rx_tvalid = 1'b1;
                m_axis_rx_tdata  = hdr2;
                m_axis_rx_tlast  = is_mrd;
            end
            ST_DATA: begin
                m_axis_rx_tvalid = 1'b1;
                m_axis_rx_tdata  = pay;
                m_axis_rx_tlast  = last_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // An MRd skips NP_WAIT when the core already has non-posted credit.
                if (accept && (i_cmd_type != CMD_RSVD)) begin
                    if ((i_cmd_type == CMD_MRD) && !rx_np_ok) state_nxt = ST_NP_WAIT;
                    else                                      state_nxt = ST_HDR0;
                end
            end
            ST_NP_WAIT: if (rx_np_ok) state_nxt = ST_HDR0;
            ST_HDR0:    if (beat) state_nxt = ST_HDR1;
            ST_HDR1:    if (beat) state_nxt = ST_HDR2;
            ST_HDR2:    if (beat) state_nxt = is_mrd ? done_state : ST_DATA;
            ST_DATA:    if (beat && last_data) state_nxt = done_state;
            ST_GAP:     if (gcnt == GAP_LAST) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            dcnt        <= '0;
            pay         <= '0;
            gcnt        <= '0;
            o_pkt_count <= '0;
            o_err_cmd   <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_err_cmd <= accept && (i_cmd_type == CMD_RSVD);
            if (accept) begin
                cmd.ctype <= cmd_type_e'(i_cmd_type);
                cmd.addr  <= i_cmd_addr;
                cmd.len   <= i_cmd_len;
                cmd.tag   <= i_cmd_tag;
                cmd.seed  <= i_cmd_seed;
            end
            if (beat && (state == ST_HDR2)) begin
                dcnt <= 11'd1;
                pay  <= cmd.seed;
            end else if (beat && (state == ST_DATA)) begin
                dcnt <= dcnt + 11'd1;
                pay  <= pay + 32'd1;
            end
            gcnt <= (state == ST_GAP) ? gcnt + 16'd1 : 16'd0;
            if (beat && m_axis_rx_tlast) o_pkt_count <= o_pkt_count + 16'd1;
        end
    end

endmodule
